uart_word_bridge: RTL and testbench
===================================

Name: uart_word_bridge

Overview:
- Parametrised byte-to-word bridge between the UART byte AXI-Stream pair and the processor's input and output word streams.
- Successor to the fixed pair of generic width adapters: adds configurable byte order, an inter-byte timeout that discards stale partial words, error-driven resynchronisation, and a saturating drop counter.
- Sits between the `uart` instance and `axis_processor` in the UART processor top level.

Parameters:
- UART_WIDTH, 8, bits per UART beat.
- INP_WIDTH, 24, processor input word width; INP_BEATS = ceil(INP_WIDTH/UART_WIDTH), must be >= 1.
- OUT_WIDTH, 16, processor output word width; OUT_BEATS = ceil(OUT_WIDTH/UART_WIDTH).
- MSB_FIRST, 0, 0 = least-significant beat first on both directions, 1 = most-significant first.
- TIMEOUT_CYCLES, 100000, clk cycles of rx silence before a partial word is discarded; 0 disables the timeout.
- DROP_CNT_WIDTH, 8, width of the drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous to clk, active-high
- rx_tdata  in  UART_WIDTH  byte from UART receiver
- rx_tvalid  in  1  byte valid
- rx_tready  out  1  byte accept
- rx_frame_error  in  1  UART frame-error pulse
- rx_overrun_error  in  1  UART overrun pulse
- inp_tdata  out  INP_WIDTH  assembled word to processor
- inp_tvalid  out  1  word valid
- inp_tready  in  1  processor accept
- out_tdata  in  OUT_WIDTH  processor output word
- out_tvalid  in  1  word valid
- out_tready  out  1  word accept
- tx_tdata  out  UART_WIDTH  byte to UART transmitter
- tx_tvalid  out  1  byte valid
- tx_tready  in  1  transmitter accept
- err_clear  in  1  clears rx_error and drop_count
- rx_error  out  1  sticky error flag
- drop_count  out  DROP_CNT_WIDTH  saturating count of discarded partial words
- rx_partial  out  1  high while 1 <= collected beats < INP_BEATS

Behaviour:
- Reset (rst high at a clk edge) gives:
  - rx FSM in COLLECT with beat count 0; tx FSM in IDLE.
  - rx_tready=1, inp_tvalid=0, inp_tdata=0, out_tready=1, tx_tvalid=0, tx_tdata=0.
  - rx_error=0, drop_count=0, rx_partial=0, timeout counter 0.
  - Reset mid-word discards all partial and held data in both directions.
- RX FSM: COLLECT -> HOLD.
  - COLLECT: rx_tready=1. Each rx handshake writes the byte into beat slot k: k = count when MSB_FIRST=0, k = INP_BEATS-1-count when MSB_FIRST=1. Then count increments.
  - When the handshake fills the last beat, go to HOLD. inp_tvalid is high the next cycle (1-cycle latency from last byte).
  - Bits of the top slot above INP_WIDTH are truncated.
  - HOLD: rx_tready=0; inp_tdata held stable while inp_tvalid && !inp_tready. On the inp handshake go to COLLECT with count 0; rx_tready=1 the following cycle.
- Timeout (TIMEOUT_CYCLES>0): counter runs only in COLLECT with count>0. It clears on every rx handshake.
  - On reaching TIMEOUT_CYCLES: count resets to 0 and drop_count increments (saturating at all-ones).
  - A byte arriving on the expiry cycle is treated as the first beat of a new word.
- Errors: rx_frame_error or rx_overrun_error sets rx_error. In COLLECT it also discards the partial word: count goes to 0, and drop_count increments only if count>0.
  - A byte handshaken in the same cycle as an error is discarded as well.
  - Errors in HOLD set rx_error only; the held word is kept.
- err_clear clears rx_error and drop_count. A simultaneous set or increment wins over the clear: the result is rx_error=1, drop_count=1 where applicable.
- TX FSM: IDLE -> SEND.
  - IDLE: out_tready=1. On the out handshake, capture the word, zero-extend it to OUT_BEATS*UART_WIDTH, and go to SEND. tx_tvalid=1 the next cycle.
  - SEND: out_tready=0. Beats are emitted in MSB_FIRST order; tx_tdata is stable until the tx handshake.
  - The handshake of beat OUT_BEATS-1 returns to IDLE.
  - If tx_tready is held high, there are no bubbles between beats of one word. There is 1 idle cycle between words.
- When INP_BEATS or OUT_BEATS is 1, the respective path degenerates to a 1-deep register slice with identical handshake rules.
- Outputs are all registered except rx_tready and out_tready, which are state decodes.

Test Plan:
- Defaults, rx bytes 0x11, 0x22, 0x33 back-to-back, inp_tready=1 -> inp_tdata=0x332211 valid 1 cycle after the third byte; rx_tready low exactly 1 cycle.
- MSB_FIRST=1, out_tdata=0xBEEF, tx_tready=1 -> tx bytes 0xBE then 0xEF on consecutive cycles; out_tready returns high the cycle after the second handshake.
- TIMEOUT_CYCLES=50, bytes 0xAA, 0xBB, then 50 idle cycles, then 0x01, 0x02, 0x03 -> drop_count=1; inp_tdata=0x030201; rx_partial low after expiry.
- Byte 0x55, then rx_frame_error pulse together with byte 0x66 -> both discarded, rx_error=1, drop_count=1. Next bytes 0x07, 0x08, 0x09 -> 0x090807.
- Word held in HOLD with inp_tready=0 for 20 cycles while rx_tvalid=1 -> rx_tready=0 throughout; inp_tdata stable. Assert err_clear in the same cycle as an overrun -> rx_error stays 1.
- rst asserted mid-word in both directions -> all outputs at reset values next cycle. A subsequent full 3-byte word is assembled correctly.

Source files
------------

// File: rtl/uart_word_bridge.sv
// Packs UART bytes into processor words and splits processor words into UART bytes.
// Word valid 1 cycle after the last byte, first tx byte 1 cycle after word accept; each side stalls its input while holding or sending.
module uart_word_bridge #(
  parameter int UART_WIDTH     = 8,
  parameter int INP_WIDTH      = 24,
  parameter int OUT_WIDTH      = 16,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_WIDTH-1:0]     rx_tdata,
  input  logic                      rx_tvalid,
  output logic                      rx_tready,
  input  logic                      rx_frame_error,
  input  logic                      rx_overrun_error,
  output logic [INP_WIDTH-1:0]      inp_tdata,
  output logic                      inp_tvalid,
  input  logic                      inp_tready,
  input  logic [OUT_WIDTH-1:0]      out_tdata,
  input  logic                      out_tvalid,
  output logic                      out_tready,
  output logic [UART_WIDTH-1:0]     tx_tdata,
  output logic                      tx_tvalid,
  input  logic                      tx_tready,
  input  logic                      err_clear,
  output logic                      rx_error,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      rx_partial
);
  localparam int INP_BEATS = (INP_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int OUT_BEATS = (OUT_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int RCW = $clog2(INP_BEATS + 1);
  localparam int TCW = $clog2(OUT_BEATS + 1);
  localparam int TMW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {COLLECT, HOLD} rx_state_t;
  typedef enum logic {IDLE, SEND} tx_state_t;

  rx_state_t                       rx_state, rx_state_nxt;
  logic [RCW-1:0]                  rx_cnt, rx_cnt_nxt, base_cnt, rx_slot;
  logic [INP_BEATS*UART_WIDTH-1:0] rx_buf, rx_buf_nxt;
  logic [TMW-1:0]                  tmo_cnt, tmo_cnt_nxt;
  logic                            rx_hs, rx_err, tmo_hit, drop_inc;
  logic                            rx_error_nxt;
  logic [DROP_CNT_WIDTH-1:0]       drop_nxt;

  tx_state_t                       tx_state, tx_state_nxt;
  logic [TCW-1:0]                  tx_cnt, tx_cnt_nxt;
  logic [OUT_BEATS*UART_WIDTH-1:0] tx_sh, tx_sh_nxt, tx_src, out_ext;
  logic [UART_WIDTH-1:0]           tx_tdata_nxt;
  logic                            tx_load;

  assign rx_tready = (rx_state == COLLECT);
  assign out_tready = (tx_state == IDLE);
  assign inp_tdata = rx_buf[INP_WIDTH-1:0];

  assign rx_hs = rx_tvalid && rx_tready;
  assign rx_err = rx_frame_error || rx_overrun_error;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (rx_state == COLLECT) && (rx_cnt != '0) && (tmo_cnt == TMO_LAST);
  // A byte landing on the expiry cycle starts a fresh word
  assign base_cnt = tmo_hit ? '0 : rx_cnt;
  assign rx_slot = (MSB_FIRST != 0) ? RCW'(INP_BEATS - 1) - base_cnt : base_cnt;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_buf_nxt   = rx_buf;
    tmo_cnt_nxt  = '0;
    drop_inc     = 1'b0;
    case (rx_state)
      COLLECT: begin
        if (rx_err) begin
          rx_cnt_nxt = '0;
          drop_inc   = (rx_cnt != '0);
        end else begin
          if (tmo_hit) begin
            rx_cnt_nxt = '0;
            drop_inc   = 1'b1;
          end
          if (rx_hs) begin
            for (int b = 0; b < INP_BEATS; b++)
              if (rx_slot == RCW'(b)) rx_buf_nxt[b*UART_WIDTH +: UART_WIDTH] = rx_tdata;
            if (base_cnt == RCW'(INP_BEATS - 1)) begin
              rx_cnt_nxt   = '0;
              rx_state_nxt = HOLD;
            end else begin
              rx_cnt_nxt = base_cnt + 1'b1;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (rx_cnt != '0) && !tmo_hit) begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
      end
      HOLD: if (inp_tready) rx_state_nxt = COLLECT;
      default: rx_state_nxt = COLLECT;
    endcase
  end

  // Set and increment take priority over a simultaneous clear
  always_comb begin
    rx_error_nxt = rx_error;
    drop_nxt     = drop_count;
    if (err_clear) begin
      rx_error_nxt = 1'b0;
      drop_nxt     = '0;
    end
    if (rx_err) rx_error_nxt = 1'b1;
    if (drop_inc) drop_nxt = err_clear ? DROP_CNT_WIDTH'(1) :
                             (&drop_count) ? drop_count : drop_count + 1'b1;
  end

  always_comb begin
    out_ext = '0;
    out_ext[OUT_WIDTH-1:0] = out_tdata;
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_sh_nxt    = tx_sh;
    tx_tdata_nxt = tx_tdata;
    tx_load      = 1'b0;
    tx_src       = tx_sh;
    case (tx_state)
      IDLE: if (out_tvalid) begin
        tx_load      = 1'b1;
        tx_src       = out_ext;
        tx_cnt_nxt   = '0;
        tx_state_nxt = SEND;
      end
      SEND: if (tx_tready) begin
        if (tx_cnt == TCW'(OUT_BEATS - 1)) begin
          tx_state_nxt = IDLE;
        end else begin
          tx_load    = 1'b1;
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
    // Remaining beats shift toward the emitting end of tx_sh
    if (tx_load) begin
      if (MSB_FIRST != 0) begin
        tx_tdata_nxt = tx_src[(OUT_BEATS-1)*UART_WIDTH +: UART_WIDTH];
        tx_sh_nxt    = tx_src << UART_WIDTH;
      end else begin
        tx_tdata_nxt = tx_src[UART_WIDTH-1:0];
        tx_sh_nxt    = tx_src >> UART_WIDTH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= COLLECT;
      rx_cnt     <= '0;
      rx_buf     <= '0;
      tmo_cnt    <= '0;
      inp_tvalid <= 1'b0;
      rx_error   <= 1'b0;
      drop_count <= '0;
      rx_partial <= 1'b0;
      tx_state   <= IDLE;
      tx_cnt     <= '0;
      tx_sh      <= '0;
      tx_tdata   <= '0;
      tx_tvalid  <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_cnt     <= rx_cnt_nxt;
      rx_buf     <= rx_buf_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      inp_tvalid <= (rx_state_nxt == HOLD);
      rx_error   <= rx_error_nxt;
      drop_count <= drop_nxt;
      rx_partial <= (rx_state_nxt == COLLECT) && (rx_cnt_nxt != '0);
      tx_state   <= tx_state_nxt;
      tx_cnt     <= tx_cnt_nxt;
      tx_sh      <= tx_sh_nxt;
      tx_tdata   <= tx_tdata_nxt;
      tx_tvalid  <= (tx_state_nxt == SEND);
    end
  end
endmodule

// File: tb/tb_uart_word_bridge.sv
// Bench for uart_word_bridge: an LSB-first instance with a 50-cycle timeout and an MSB-first instance with no timeout.
module tb_uart_word_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  a_rx_tdata, b_rx_tdata, a_tx_tdata, b_tx_tdata;
  logic        a_rx_tvalid, b_rx_tvalid, a_rx_tready, b_rx_tready;
  logic        a_rx_frame_error, b_rx_frame_error, a_rx_overrun_error, b_rx_overrun_error;
  logic [23:0] a_inp_tdata, b_inp_tdata;
  logic        a_inp_tvalid, b_inp_tvalid, a_inp_tready, b_inp_tready;
  logic [15:0] a_out_tdata, b_out_tdata;
  logic        a_out_tvalid, b_out_tvalid, a_out_tready, b_out_tready;
  logic        a_tx_tvalid, b_tx_tvalid, a_tx_tready, b_tx_tready;
  logic        a_err_clear, b_err_clear, a_rx_error, b_rx_error;
  logic [7:0]  a_drop_count, b_drop_count;
  logic        a_rx_partial, b_rx_partial;

  uart_word_bridge #(.MSB_FIRST(0), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .rst(rst),
    .rx_tdata(a_rx_tdata), .rx_tvalid(a_rx_tvalid), .rx_tready(a_rx_tready),
    .rx_frame_error(a_rx_frame_error), .rx_overrun_error(a_rx_overrun_error),
    .inp_tdata(a_inp_tdata), .inp_tvalid(a_inp_tvalid), .inp_tready(a_inp_tready),
    .out_tdata(a_out_tdata), .out_tvalid(a_out_tvalid), .out_tready(a_out_tready),
    .tx_tdata(a_tx_tdata), .tx_tvalid(a_tx_tvalid), .tx_tready(a_tx_tready),
    .err_clear(a_err_clear), .rx_error(a_rx_error), .drop_count(a_drop_count),
    .rx_partial(a_rx_partial)
  );

  uart_word_bridge #(.MSB_FIRST(1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .rx_tdata(b_rx_tdata), .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready),
    .rx_frame_error(b_rx_frame_error), .rx_overrun_error(b_rx_overrun_error),
    .inp_tdata(b_inp_tdata), .inp_tvalid(b_inp_tvalid), .inp_tready(b_inp_tready),
    .out_tdata(b_out_tdata), .out_tvalid(b_out_tvalid), .out_tready(b_out_tready),
    .tx_tdata(b_tx_tdata), .tx_tvalid(b_tx_tvalid), .tx_tready(b_tx_tready),
    .err_clear(b_err_clear), .rx_error(b_rx_error), .drop_count(b_drop_count),
    .rx_partial(b_rx_partial)
  );

  // Reference: first byte received is the low byte (or the high byte when msb)
  function automatic logic [23:0] word_of(input logic [7:0] f, input logic [7:0] s,
                                          input logic [7:0] t, input bit msb);
    int unsigned v;
    if (msb) v = f * 65536 + s * 256 + t;
    else     v = f + s * 256 + t * 65536;
    return 24'(v);
  endfunction

  function automatic logic [7:0] tx_byte(input logic [15:0] w, input int i, input bit msb);
    int unsigned pos;
    pos = msb ? 1 - i : i;
    return 8'((int'(w) >> (8 * pos)) & 255);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_send(input logic [7:0] b);
    a_rx_tdata = b;
    a_rx_tvalid = 1'b1;
    tick;
    a_rx_tvalid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] b);
    b_rx_tdata = b;
    b_rx_tvalid = 1'b1;
    tick;
    b_rx_tvalid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, {a_rx_tready, a_inp_tvalid, a_inp_tdata, a_out_tready, a_tx_tvalid, a_tx_tdata,
                      a_rx_error, a_drop_count, a_rx_partial},
        {1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0});
    chk({tag, "_b"}, {b_rx_tready, b_inp_tvalid, b_inp_tdata, b_out_tready, b_tx_tvalid, b_tx_tdata,
                      b_rx_error, b_drop_count, b_rx_partial},
        {1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0});
  endtask

  logic [7:0]  rxq[$];
  logic [23:0] expw[$];
  logic [15:0] outq[$];
  logic [7:0]  expb[$];
  logic [7:0]  r0, r1, r2, got_b;
  logic [15:0] ow;
  logic [23:0] got_w, held;
  bit          rx_hs, inp_hs, out_hs, tx_hs;
  int          cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {a_rx_tdata, a_rx_tvalid, a_rx_frame_error, a_rx_overrun_error, a_inp_tready} = '0;
    {a_out_tdata, a_out_tvalid, a_tx_tready, a_err_clear} = '0;
    {b_rx_tdata, b_rx_tvalid, b_rx_frame_error, b_rx_overrun_error, b_inp_tready} = '0;
    {b_out_tdata, b_out_tvalid, b_tx_tready, b_err_clear} = '0;
    rst = 1'b1;
    tick;
    tick;
    chk_reset("reset");
    rst = 1'b0;

    // Three bytes back-to-back, LSB-first and MSB-first
    a_inp_tready = 1'b1;
    a_send(8'h11);
    chk("partial_after_first", a_rx_partial, 1'b1);
    a_send(8'h22);
    a_send(8'h33);
    chk("lsb_word_valid", a_inp_tvalid, 1'b1);
    chk("lsb_word_data", a_inp_tdata, word_of(8'h11, 8'h22, 8'h33, 1'b0));
    chk("rx_tready_hold", a_rx_tready, 1'b0);
    tick;
    chk("rx_tready_back", a_rx_tready, 1'b1);
    chk("inp_tvalid_cleared", a_inp_tvalid, 1'b0);
    b_inp_tready = 1'b1;
    b_send(8'h11);
    b_send(8'h22);
    b_send(8'h33);
    chk("msb_word_data", {b_inp_tvalid, b_inp_tdata}, {1'b1, word_of(8'h11, 8'h22, 8'h33, 1'b1)});
    tick;

    // Word to bytes, both orders
    b_tx_tready = 1'b1;
    b_out_tdata = 16'hBEEF;
    b_out_tvalid = 1'b1;
    tick;
    b_out_tvalid = 1'b0;
    chk("msb_tx_first", {b_tx_tvalid, b_tx_tdata, b_out_tready}, {1'b1, tx_byte(16'hBEEF, 0, 1'b1), 1'b0});
    tick;
    chk("msb_tx_second", {b_tx_tvalid, b_tx_tdata}, {1'b1, tx_byte(16'hBEEF, 1, 1'b1)});
    tick;
    chk("msb_tx_done", {b_tx_tvalid, b_out_tready}, {1'b0, 1'b1});
    a_tx_tready = 1'b1;
    a_out_tdata = 16'hBEEF;
    a_out_tvalid = 1'b1;
    tick;
    a_out_tvalid = 1'b0;
    chk("lsb_tx_first", {a_tx_tvalid, a_tx_tdata}, {1'b1, tx_byte(16'hBEEF, 0, 1'b0)});
    tick;
    chk("lsb_tx_second", {a_tx_tvalid, a_tx_tdata}, {1'b1, tx_byte(16'hBEEF, 1, 1'b0)});
    tick;

    // Inter-byte timeout
    do_reset;
    a_send(8'hAA);
    a_send(8'hBB);
    repeat (49) tick;
    chk("tmo_pre_partial", a_rx_partial, 1'b1);
    chk("tmo_pre_drop", a_drop_count, 8'd0);
    tick;
    chk("tmo_drop", a_drop_count, 8'd1);
    chk("tmo_partial_low", a_rx_partial, 1'b0);
    a_send(8'h01);
    a_send(8'h02);
    a_send(8'h03);
    chk("tmo_next_word", {a_inp_tvalid, a_inp_tdata}, {1'b1, word_of(8'h01, 8'h02, 8'h03, 1'b0)});
    tick;
    a_send(8'hCC);
    repeat (49) tick;
    a_send(8'hDD);
    a_send(8'hEE);
    a_send(8'hFF);
    chk("tmo_expiry_byte", {a_inp_tvalid, a_inp_tdata}, {1'b1, word_of(8'hDD, 8'hEE, 8'hFF, 1'b0)});
    chk("tmo_drop_two", a_drop_count, 8'd2);
    tick;

    // Error resynchronisation and clear priority
    do_reset;
    a_send(8'h55);
    a_rx_tdata = 8'h66;
    a_rx_tvalid = 1'b1;
    a_rx_frame_error = 1'b1;
    tick;
    a_rx_tvalid = 1'b0;
    a_rx_frame_error = 1'b0;
    chk("err_flags", {a_rx_error, a_drop_count, a_rx_partial}, {1'b1, 8'd1, 1'b0});
    a_send(8'h07);
    a_send(8'h08);
    a_send(8'h09);
    chk("err_next_word", {a_inp_tvalid, a_inp_tdata}, {1'b1, word_of(8'h07, 8'h08, 8'h09, 1'b0)});
    tick;
    a_send(8'h44);
    a_rx_overrun_error = 1'b1;
    a_err_clear = 1'b1;
    tick;
    a_rx_overrun_error = 1'b0;
    chk("clear_vs_inc", {a_rx_error, a_drop_count}, {1'b1, 8'd1});
    tick;
    a_err_clear = 1'b0;
    chk("clear_only", {a_rx_error, a_drop_count}, {1'b0, 8'd0});
    a_rx_frame_error = 1'b1;
    tick;
    a_rx_frame_error = 1'b0;
    chk("err_empty_no_drop", {a_rx_error, a_drop_count}, {1'b1, 8'd0});

    // Backpressure in HOLD
    do_reset;
    a_inp_tready = 1'b0;
    a_send(8'hA1);
    a_send(8'hB2);
    a_send(8'hC3);
    held = word_of(8'hA1, 8'hB2, 8'hC3, 1'b0);
    a_rx_tdata = 8'hDD;
    a_rx_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("hold_stall", {a_rx_tready, a_inp_tvalid, a_inp_tdata}, {1'b0, 1'b1, held});
      tick;
    end
    a_rx_overrun_error = 1'b1;
    a_err_clear = 1'b1;
    tick;
    a_rx_overrun_error = 1'b0;
    a_err_clear = 1'b0;
    chk("hold_err", {a_rx_error, a_drop_count, a_inp_tvalid, a_inp_tdata}, {1'b1, 8'd0, 1'b1, held});
    a_rx_tvalid = 1'b0;
    a_inp_tready = 1'b1;
    tick;
    chk("hold_release", {a_inp_tvalid, a_rx_tready}, {1'b0, 1'b1});

    // Reset in the middle of both directions
    do_reset;
    a_send(8'h12);
    b_tx_tready = 1'b0;
    b_out_tdata = 16'h1234;
    b_out_tvalid = 1'b1;
    tick;
    b_out_tvalid = 1'b0;
    chk("midword_pre", {a_rx_partial, b_tx_tvalid}, {1'b1, 1'b1});
    rst = 1'b1;
    tick;
    chk_reset("midword_rst");
    rst = 1'b0;
    a_send(8'h21);
    a_send(8'h43);
    a_send(8'h65);
    chk("post_rst_word", {a_inp_tvalid, a_inp_tdata}, {1'b1, word_of(8'h21, 8'h43, 8'h65, 1'b0)});
    tick;

    // Random traffic with random backpressure against the queue model
    do_reset;
    for (int n = 0; n < 20; n++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      rxq.push_back(r0);
      rxq.push_back(r1);
      rxq.push_back(r2);
      expw.push_back(word_of(r0, r1, r2, 1'b0));
      ow = 16'($urandom);
      outq.push_back(ow);
      expb.push_back(tx_byte(ow, 0, 1'b1));
      expb.push_back(tx_byte(ow, 1, 1'b1));
    end
    cyc = 0;
    while ((rxq.size() + expw.size() + outq.size() + expb.size()) != 0 && cyc < 4000) begin
      if (!a_rx_tvalid && rxq.size() != 0 && $urandom_range(3) != 0) begin
        a_rx_tvalid = 1'b1;
        a_rx_tdata = rxq[0];
      end
      a_inp_tready = ($urandom_range(1) == 1);
      if (!b_out_tvalid && outq.size() != 0 && $urandom_range(3) != 0) begin
        b_out_tvalid = 1'b1;
        b_out_tdata = outq[0];
      end
      b_tx_tready = ($urandom_range(1) == 1);
      rx_hs  = a_rx_tvalid && a_rx_tready;
      inp_hs = a_inp_tvalid && a_inp_tready;
      out_hs = b_out_tvalid && b_out_tready;
      tx_hs  = b_tx_tvalid && b_tx_tready;
      got_w  = a_inp_tdata;
      got_b  = b_tx_tdata;
      tick;
      if (rx_hs) begin
        void'(rxq.pop_front());
        a_rx_tvalid = 1'b0;
      end
      if (out_hs) begin
        void'(outq.pop_front());
        b_out_tvalid = 1'b0;
      end
      if (inp_hs) begin
        if (expw.size() == 0) chk("rand_extra_word", got_w, 24'hx);
        else chk("rand_word", got_w, expw.pop_front());
      end
      if (tx_hs) begin
        if (expb.size() == 0) chk("rand_extra_byte", got_b, 8'hx);
        else chk("rand_byte", got_b, expb.pop_front());
      end
      cyc++;
    end
    chk("rand_drained", rxq.size() + expw.size() + outq.size() + expb.size(), 0);
    chk("rand_no_drops", a_drop_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
